bt_status_tx: RTL and testbench

- UART (8N1) transmitter for the Bluetooth module's RX line; the return path of the command receiver.
- Reports player status to the phone: song-finished event, pause state, song select and volume.
- Sits beside the Bluetooth receiver in top. Samples the same vol/song_select/pause nets plus the mp3 finish pulse.
- Sends a fixed-format packet whenever any reported value changes.

---
 rtl/bt_status_tx.sv | 186 ++++++++++++++++++
 tb/tb_bt_status_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bt_status_tx.sv
// bt_status_tx: 8N1 UART transmitter that reports player status to the
// Bluetooth module. Whenever the song select, pause state or volume changes,
// or the mp3 finish pulse fires, it sends one packet:
//   A5, {5'b0, finish_flag, pause, song_select}, vol[15:8], vol[7:0]
// Events that arrive while a packet is in flight are held and cause a
// follow-up packet. After reset, one "hello" packet goes out unprompted.
//
// Optional feature: define STATUS_CHECKSUM_EN to append a fifth byte
// B1^B2^B3 to every packet.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_FINISH       single-cycle pulse, current song finished
//   i_song_select  current song select
//   i_pause        current pause state
//   i_vol          current volume word
//   o_tx           UART TX line (idles high)
//   o_busy         high while a packet is being shifted out
module bt_status_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_FINISH,
  input  logic        i_song_select,
  input  logic        i_pause,
  input  logic [15:0] i_vol,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef STATUS_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          pending_q, pending_d;
  logic          finish_q, finish_d;
  logic          song_prev_q, pause_prev_q;
  logic [15:0]   vol_prev_q;
  logic [7:0]    b1_q, b2_q, b3_q;
`ifdef STATUS_CHECKSUM_EN
  logic [7:0]    b4_q;
`endif

  logic       launch, change, baud_end, last_byte;
  logic [7:0] cur_byte;

  assign change    = (i_song_select != song_prev_q) || (i_pause != pause_prev_q) ||
                     (i_vol != vol_prev_q);
  assign launch    = (state_q == S_IDLE) && pending_q;
  assign baud_end  = (baud_q == CW'(DIV - 1));
  assign last_byte = (byte_q == 3'(NBYTES - 1));

  // Launch consumes the pending/finish flags, but an event landing in the
  // same cycle re-arms them so a follow-up packet carries it.
  assign pending_d = (pending_q && !launch) || change || i_FINISH;
  assign finish_d  = (finish_q  && !launch) || i_FINISH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= 1'b1;
      finish_q     <= 1'b0;
      song_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      vol_prev_q   <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
`ifdef STATUS_CHECKSUM_EN
      b4_q         <= '0;
`endif
    end else begin
      pending_q    <= pending_d;
      finish_q     <= finish_d;
      song_prev_q  <= i_song_select;
      pause_prev_q <= i_pause;
      vol_prev_q   <= i_vol;
      if (launch) begin
        b1_q <= {5'b0, finish_q, i_pause, i_song_select};
        b2_q <= i_vol[15:8];
        b3_q <= i_vol[7:0];
`ifdef STATUS_CHECKSUM_EN
        b4_q <= {5'b0, finish_q, i_pause, i_song_select} ^ i_vol[15:8] ^ i_vol[7:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE:  if (pending_q) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_START;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else baud_d = baud_q + CW'(1);
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else baud_d = baud_q + CW'(1);
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (last_byte) state_d = S_IDLE;
          else begin
            byte_d  = byte_q + 3'd1;
            state_d = S_START;
          end
        end else baud_d = baud_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = SYNC;
    case (byte_q)
      3'd1:    cur_byte = b1_q;
      3'd2:    cur_byte = b2_q;
      3'd3:    cur_byte = b3_q;
`ifdef STATUS_CHECKSUM_EN
      3'd4:    cur_byte = b4_q;
`endif
      default: cur_byte = SYNC;
    endcase
  end

  // Outputs decode straight from state so reset forces the line high at once.
  // Busy drops in the final cycle of the last stop bit.
  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = cur_byte[bit_q];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy = (state_q != S_IDLE) &&
                  !((state_q == S_STOP) && baud_end && last_byte);

endmodule

// File: tb/tb_bt_status_tx.sv
// Testbench for bt_status_tx with DIV = 10. Whole packets are captured as a
// per-cycle trace of o_tx/o_busy and compared with the ideal 8N1 waveform
// built from the expected bytes.
module tb_bt_status_tx;
  localparam int DIV = 10;
`ifdef STATUS_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int PW = NB * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_FINISH = 1'b0;
  logic        i_song_select = 1'b0;
  logic        i_pause = 1'b0;
  logic [15:0] i_vol = '0;
  logic        o_tx, o_busy;

  int   n_vec = 0;
  int   n_mis = 0;
  logic wave[PW];
  logic busyw[PW];

  typedef struct {
    logic [15:0] vol;
    logic        pause;
    logic        sel;
    logic        fin;
    logic [7:0]  b1, b2, b3;
  } vec_t;
  vec_t tab[5];

  bt_status_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .i_FINISH(i_FINISH), .i_song_select(i_song_select),
    .i_pause(i_pause), .i_vol(i_vol), .o_tx(o_tx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Counts falling edges until the line drops; i_FINISH is a one-cycle pulse.
  task automatic wait_start(input string name, input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      i_FINISH = 1'b0;
      lat++;
    end while (o_tx !== 1'b0 && lat < limit);
    if (o_tx !== 1'b0) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: no start bit within %0d cycles", name, limit);
      lat = -1;
    end
  endtask

  // Sample 0 is the current (first start-bit) cycle.
  task automatic record_packet(input int pulse_at);
    wave[0]  = o_tx;
    busyw[0] = o_busy;
    for (int i = 1; i < PW; i++) begin
      @(negedge clk);
      wave[i]  = o_tx;
      busyw[i] = o_busy;
      i_FINISH = (i == pulse_at);
    end
  endtask

  task automatic check_packet(input string name, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] eb[5];
    logic [7:0] got;
    logic       ew;
    int         bad, bb;
    eb[0] = 8'hA5; eb[1] = b1; eb[2] = b2; eb[3] = b3; eb[4] = b1 ^ b2 ^ b3;
    bad = 0;
    for (int k = 0; k < NB; k++) begin
      for (int s = 0; s < 10 * DIV; s++) begin
        int slot;
        slot = s / DIV;  // 0 start, 1..8 data LSB first, 9 stop
        if (slot == 0)      ew = 1'b0;
        else if (slot == 9) ew = 1'b1;
        else                ew = eb[k][slot-1];
        if (wave[k*10*DIV + s] !== ew) bad++;
      end
    end
    chk({name, " waveform bad samples"}, bad, 0);
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < 8; j++) got[j] = wave[k*10*DIV + (j+1)*DIV + DIV/2];
      chk($sformatf("%s byte%0d", name, k), {24'd0, got}, {24'd0, eb[k]});
    end
    bb = 0;
    for (int i = 0; i < PW - 1; i++) if (busyw[i] !== 1'b1) bb++;
    if (busyw[PW-1] !== 1'b0) bb++;
    chk({name, " busy profile bad samples"}, bb, 0);
  endtask

  task automatic quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    chk({name, " idle bad cycles"}, bad, 0);
  endtask

  initial begin
    int lat;
    tab[0] = '{16'h1234, 1'b1, 1'b0, 1'b0, 8'h02, 8'h12, 8'h34};
    tab[1] = '{16'h1234, 1'b1, 1'b1, 1'b1, 8'h07, 8'h12, 8'h34};
    tab[2] = '{16'hABCD, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAB, 8'hCD};
    tab[3] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 8'h03, 8'hFF, 8'hFF};
    tab[4] = '{16'h0000, 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 8'h00};

    // Reset and hello packet: one IDLE cycle, one LOAD cycle, then start bit.
    repeat (3) @(negedge clk);
    chk("reset o_tx", 32'(o_tx), 1);
    chk("reset o_busy", 32'(o_busy), 0);
    rst_n = 1'b1;
    wait_start("hello", 50, lat);
    chk("hello latency", lat, 2);
    record_packet(-1);
    check_packet("hello", 8'h00, 8'h00, 8'h00);
    quiet("after hello", 30);

    // Table: inputs applied while idle; the change/pulse is sampled on the
    // next edge, then launch, LOAD, start bit -> third falling edge.
    foreach (tab[i]) begin
      i_vol = tab[i].vol; i_pause = tab[i].pause;
      i_song_select = tab[i].sel; i_FINISH = tab[i].fin;
      wait_start($sformatf("vec%0d", i), 50, lat);
      chk($sformatf("vec%0d latency", i), lat, 3);
      record_packet(-1);
      check_packet($sformatf("vec%0d", i), tab[i].b1, tab[i].b2, tab[i].b3);
      quiet($sformatf("vec%0d", i), 20);
    end

    // Finish pulse in the middle of byte B2: packet unchanged, then one idle
    // cycle, LOAD, and a follow-up with the finish flag set.
    i_vol = 16'h5555;
    wait_start("midB2", 50, lat);
    record_packet(2 * 10 * DIV + 50);
    check_packet("midB2 inflight", 8'h01, 8'h55, 8'h55);
    wait_start("midB2 followup", 50, lat);
    chk("midB2 followup gap", lat, 3);
    record_packet(-1);
    check_packet("midB2 followup", 8'h05, 8'h55, 8'h55);
    quiet("midB2", 20);

    // Randomized status changes against the packet-format rules.
    for (int r = 0; r < 10; r++) begin
      logic [15:0] nv;
      logic        np, ns, nf;
      nv = 16'($urandom);
      np = 1'($urandom);
      ns = 1'($urandom);
      nf = ($urandom_range(0, 2) == 0);
      if (!nf && nv == i_vol && np == i_pause && ns == i_song_select) nv = i_vol ^ 16'h0100;
      i_vol = nv; i_pause = np; i_song_select = ns; i_FINISH = nf;
      wait_start($sformatf("rand%0d", r), 50, lat);
      chk($sformatf("rand%0d latency", r), lat, 3);
      record_packet(-1);
      check_packet($sformatf("rand%0d", r), {5'b0, nf, np, ns}, nv[15:8], nv[7:0]);
      quiet($sformatf("rand%0d", r), 5);
    end

    // Reset in the middle of B1 (B1=04, line low at sample 150).
    i_vol = 16'h0000; i_pause = 1'b0; i_song_select = 1'b0; i_FINISH = 1'b1;
    wait_start("rst mid", 50, lat);
    repeat (150) @(negedge clk);
    chk("pre-reset line low", 32'(o_tx), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset o_tx", 32'(o_tx), 1);
    chk("async reset o_busy", 32'(o_busy), 0);
    repeat (3) @(negedge clk);
    chk("held reset o_tx", 32'(o_tx), 1);
    rst_n = 1'b1;
    wait_start("rehello", 50, lat);
    chk("rehello latency", lat, 2);
    record_packet(-1);
    check_packet("rehello", 8'h00, 8'h00, 8'h00);
    quiet("after rehello", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
